// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the set-associative instruction cache.
package icache_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag and line storage for every set plus tag compare.
module icache_way
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned IB         = 6,
    parameter int unsigned TB         = 22,
    parameter int unsigned WB         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IB-1:0]                index,
    input  logic [TB-1:0]                tag,
    input  logic [WB-1:0]                word,
    input  logic                         wr_en,
    input  logic [WORD_W*LINE_WORDS-1:0] wr_line,
    input  logic                         inv_all,
    output logic                         match,
    output logic                         valid,
    output logic [WORD_W-1:0]            data
);

    logic [NUM_SETS-1:0]           valid_q;
    logic [TB-1:0]                 tag_q  [NUM_SETS];
    logic [WORD_W*LINE_WORDS-1:0]  line_q [NUM_SETS];
    logic [WORD_W*LINE_WORDS-1:0]  line_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[index]  <= tag;
            line_q[index] <= wr_line;
        end
    end

    assign valid   = valid_q[index];
    assign match   = valid && (tag_q[index] == tag);
    assign line_rd = line_q[index];
    assign data    = line_rd[WORD_W*word +: WORD_W];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with single-beat line refill, LRU replacement and flush.
module icache_sa
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS   = 64,
    parameter int unsigned NUM_WAYS   = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         read_en,
    input  logic                         flush,
    output logic [WORD_W-1:0]            data_out,
    output logic                         hit,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_req,
    input  logic [WORD_W*LINE_WORDS-1:0] mem_data_in,
    input  logic                         mem_ready
);

    localparam int unsigned OB = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IB = $clog2(NUM_SETS);
    localparam int unsigned TB = ADDR_W - OB - IB;
    localparam int unsigned WB = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    state_t               state_q, state_d;
    logic [ADDR_W-1:OB]   miss_line_q, miss_line_d;
    logic                 flush_pending_q, flush_pending_d;
    logic [NUM_SETS-1:0]  lru_q;

    logic [ADDR_W-1:0]    look_addr;
    logic [IB-1:0]        look_index;
    logic [TB-1:0]        look_tag;
    logic [WB-1:0]        word_sel;

    logic [NUM_WAYS-1:0]  way_match;
    logic [NUM_WAYS-1:0]  way_valid;
    logic [NUM_WAYS-1:0]  way_wr;
    logic [WORD_W-1:0]    way_data [NUM_WAYS];

    logic                 any_match;
    logic [WORD_W-1:0]    match_data;
    logic                 hit_way;
    logic                 victim;
    logic                 install;
    logic                 inv_all;
    logic                 unused_addr;

    assign unused_addr = ^addr[1:0];

    // While refilling, the arrays are indexed by the latched miss so victim choice is stable.
    assign look_addr  = (state_q == REFILL) ? {miss_line_q, OB'(0)} : addr;
    assign look_index = look_addr[OB +: IB];
    assign look_tag   = look_addr[ADDR_W-1 -: TB];
    assign word_sel   = WB'(addr[ADDR_W-1:2] & 30'(LINE_WORDS - 1));

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        assign way_wr[g] = install && (victim == 1'(g));

        icache_way #(
            .NUM_SETS   (NUM_SETS),
            .LINE_WORDS (LINE_WORDS),
            .IB         (IB),
            .TB         (TB),
            .WB         (WB)
        ) u_way (
            .clk     (clk),
            .rst     (rst),
            .index   (look_index),
            .tag     (look_tag),
            .word    (word_sel),
            .wr_en   (way_wr[g]),
            .wr_line (mem_data_in),
            .inv_all (inv_all),
            .match   (way_match[g]),
            .valid   (way_valid[g]),
            .data    (way_data[g])
        );
    end

    always_comb begin
        any_match  = 1'b0;
        match_data = '0;
        hit_way    = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_match[w]) begin
                any_match  = 1'b1;
                match_data = match_data | way_data[w];
                hit_way    = 1'(w);
            end
        end
    end

    if (NUM_WAYS == 2) begin : g_lru_victim
        always_comb begin
            if (!way_valid[0]) begin
                victim = 1'b0;
            end else if (!way_valid[1]) begin
                victim = 1'b1;
            end else begin
                victim = lru_q[look_index];
            end
        end
    end else begin : g_direct_victim
        assign victim = 1'b0;
    end

    assign hit      = (state_q == IDLE) && read_en && !flush && any_match;
    assign data_out = hit ? match_data : '0;
    assign mem_req  = (state_q == REFILL);
    assign mem_addr = {miss_line_q, OB'(0)};

    // A flush seen at any point during the refill drops the returning line.
    assign install  = (state_q == REFILL) && mem_ready && !flush_pending_q && !flush;
    assign inv_all  = ((state_q == IDLE) && flush) ||
                      ((state_q == REFILL) && mem_ready && (flush_pending_q || flush));

    always_comb begin
        state_d         = state_q;
        miss_line_d     = miss_line_q;
        flush_pending_d = flush_pending_q;
        unique case (state_q)
            IDLE: begin
                if (!flush && read_en && !any_match) begin
                    state_d     = REFILL;
                    miss_line_d = addr[ADDR_W-1:OB];
                end
            end
            REFILL: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d         = IDLE;
                    flush_pending_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            miss_line_q     <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            miss_line_q     <= miss_line_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_q <= '0;
        end else if (inv_all) begin
            lru_q <= '0;
        end else if (hit) begin
            lru_q[look_index] <= ~hit_way;
        end else if (install) begin
            lru_q[look_index] <= ~victim;
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Randomized scoreboard bench for icache_sa against a recency-list cache model.
module tb_icache_sa;

    localparam int unsigned NSETS = 64;

    logic         clk;
    logic         rst;
    logic [31:0]  addr;
    logic         read_en;
    logic         flush;
    logic [31:0]  data_out;
    logic         hit;
    logic [31:0]  mem_addr;
    logic         mem_req;
    logic [127:0] mem_data_in;
    logic         mem_ready;

    logic [31:0]  s_addr;
    logic         s_read_en;
    logic [31:0]  s_data_out;
    logic         s_hit;
    logic [31:0]  s_mem_addr;
    logic         s_mem_req;
    logic [127:0] s_mem_data_in;
    logic         s_mem_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  exp_q [$];
    int unsigned  mru [NSETS][$];
    logic [127:0] ldata [int unsigned];

    icache_sa dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .read_en     (read_en),
        .flush       (flush),
        .data_out    (data_out),
        .hit         (hit),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_data_in (mem_data_in),
        .mem_ready   (mem_ready)
    );

    icache_sa #(
        .NUM_SETS   (16),
        .NUM_WAYS   (1),
        .LINE_WORDS (4)
    ) dut_dm (
        .clk         (clk),
        .rst         (rst),
        .addr        (s_addr),
        .read_en     (s_read_en),
        .flush       (1'b0),
        .data_out    (s_data_out),
        .hit         (s_hit),
        .mem_addr    (s_mem_addr),
        .mem_req     (s_mem_req),
        .mem_data_in (s_mem_data_in),
        .mem_ready   (s_mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] gen_line(input logic [31:0] line);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = (line * 32'h9E37_79B1) ^ (32'(k) * 32'h0100_0193 + 32'h0000_1234);
        end
        return l;
    endfunction

    function automatic int unsigned set_of(input int unsigned line);
        return (line >> 4) % NSETS;
    endfunction

    function automatic bit model_has(input int unsigned line);
        int unsigned s = set_of(line);
        for (int i = 0; i < mru[s].size(); i++) begin
            if (mru[s][i] == line) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Front of each set's list is the most recently used line.
    function automatic void model_touch(input int unsigned line);
        int unsigned s = set_of(line);
        for (int i = 0; i < mru[s].size(); i++) begin
            if (mru[s][i] == line) begin
                mru[s].delete(i);
                break;
            end
        end
        mru[s].push_front(line);
    endfunction

    function automatic void model_install(input int unsigned line, input logic [127:0] d);
        int unsigned s = set_of(line);
        if (mru[s].size() >= 2) void'(mru[s].pop_back());
        mru[s].push_front(line);
        ldata[line] = d;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NSETS; s++) mru[s].delete();
    endfunction

    // Monitor: every DUT hit consumes one expected word; no hit means data_out must be zero.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (hit === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_hit: got data %h, expected no hit", data_out);
                end else begin
                    check_eq("data_out", data_out, exp_q.pop_front());
                end
            end else begin
                check_eq("data_out_nohit", data_out, 32'h0);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int want, input bit use_line,
                         input logic [127:0] sup_line);
        int unsigned  line = a & ~32'hF;
        int unsigned  w    = (a >> 2) & 3;
        bit           pred = model_has(line);
        logic [127:0] d;
        int           dly;
        @(negedge clk);
        addr    = a;
        read_en = 1'b1;
        if (pred) begin
            d = ldata[line];
            exp_q.push_back(d[32*w +: 32]);
        end else begin
            d = use_line ? sup_line : gen_line(line);
            exp_q.push_back(d[32*w +: 32]);
        end
        #3;
        check_eq("hit_pred", 32'(hit), 32'(pred));
        if (want >= 0) check_eq("hit_want", 32'(hit), 32'(want));
        if (!pred) begin
            dly = $urandom_range(0, 2);
            for (int c = 0; c <= dly; c++) begin
                @(negedge clk);
                if (c < dly) begin
                    addr        = $urandom;
                    mem_data_in = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    addr        = a;
                    mem_ready   = 1'b1;
                    mem_data_in = d;
                end
                #3;
                check_eq("mem_req", 32'(mem_req), 32'h1);
                check_eq("mem_addr", mem_addr, line);
                check_eq("refill_hit", 32'(hit), 32'h0);
            end
            @(negedge clk);
            mem_ready   = 1'b0;
            mem_data_in = {$urandom, $urandom, $urandom, $urandom};
            #3;
            check_eq("fill_hit", 32'(hit), 32'h1);
            check_eq("fill_mem_req", 32'(mem_req), 32'h0);
            model_install(line, d);
        end else begin
            model_touch(line);
        end
        @(posedge clk);
        #1 read_en = 1'b0;
    endtask

    task automatic fetch_dm(input logic [31:0] a, input logic want);
        logic [127:0] d = gen_line(a & ~32'hF);
        int unsigned  w = (a >> 2) & 3;
        @(negedge clk);
        s_addr    = a;
        s_read_en = 1'b1;
        #3;
        check_eq("dm_hit", 32'(s_hit), 32'(want));
        if (!want) begin
            @(negedge clk);
            s_mem_ready   = 1'b1;
            s_mem_data_in = d;
            #3;
            check_eq("dm_mem_addr", s_mem_addr, a & ~32'hF);
            @(negedge clk);
            s_mem_ready = 1'b0;
            #3;
            check_eq("dm_fill_hit", 32'(s_hit), 32'h1);
        end
        check_eq("dm_data", s_data_out, d[32*w +: 32]);
        @(posedge clk);
        #1 s_read_en = 1'b0;
    endtask

    task automatic flush_idle(input logic [31:0] a);
        @(negedge clk);
        addr    = a;
        read_en = 1'b1;
        flush   = 1'b1;
        #3;
        check_eq("flush_hit", 32'(hit), 32'h0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        read_en = 1'b0;
        model_clear();
    endtask

    initial begin
        logic [127:0] cold;
        logic [31:0]  ra;
        rst = 1'b0;
        addr = '0;
        read_en = 1'b0;
        flush = 1'b0;
        mem_data_in = '0;
        mem_ready = 1'b0;
        s_addr = '0;
        s_read_en = 1'b0;
        s_mem_data_in = '0;
        s_mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_hit", 32'(hit), 32'h0);
        check_eq("rst_data", data_out, 32'h0);
        rst = 1'b1;

        // Cold miss with a recognisable word 1.
        cold = gen_line(32'h1000);
        cold[63:32] = 32'hDEAD_BEEF;
        fetch(32'h0000_1004, 0, 1'b1, cold);

        // Two-way conflict set at index 0.
        fetch(32'h0000_1000, 1, 1'b0, '0);
        fetch(32'h0000_1400, 0, 1'b0, '0);
        fetch(32'h0000_1000, 1, 1'b0, '0);
        fetch(32'h0000_1800, 0, 1'b0, '0);
        fetch(32'h0000_1000, 1, 1'b0, '0);
        fetch(32'h0000_1400, 0, 1'b0, '0);

        // Held hit while mem_ready is pulsed spuriously.
        fetch(32'h0000_1008, 1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr        = 32'h0000_1008;
            read_en     = 1'b1;
            mem_ready   = (i == 1);
            mem_data_in = {$urandom, $urandom, $urandom, $urandom};
            cold        = ldata[32'h1000];
            exp_q.push_back(cold[95:64]);
            #3;
            check_eq("held_hit", 32'(hit), 32'h1);
            check_eq("held_mem_req", 32'(mem_req), 32'h0);
        end
        @(posedge clk);
        #1;
        read_en   = 1'b0;
        mem_ready = 1'b0;

        // Direct-mapped instance: same-index lines evict each other.
        fetch_dm(32'h0000_0100, 1'b0);
        fetch_dm(32'h0000_0104, 1'b1);
        fetch_dm(32'h0000_0200, 1'b0);
        fetch_dm(32'h0000_0100, 1'b0);

        for (int n = 0; n < 300; n++) begin
            ra = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 2) << 4) |
                 ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) flush_idle(ra);
            else fetch(ra, -1, 1'b0, '0);
        end

        // Reset during a refill.
        flush_idle(32'h0);
        fetch(32'h0000_1000, 0, 1'b0, '0);
        @(negedge clk);
        addr    = 32'h0000_3010;
        read_en = 1'b1;
        #3;
        check_eq("pre_rst_hit", 32'(hit), 32'h0);
        @(negedge clk);
        #1;
        check_eq("pre_rst_mem_req", 32'(mem_req), 32'h1);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_mid_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mid_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mid_hit", 32'(hit), 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        read_en = 1'b0;
        model_clear();
        fetch(32'h0000_1000, 0, 1'b0, '0);

        // Flush during a refill discards the returning line.
        flush_idle(32'h0);
        @(negedge clk);
        addr    = 32'h0000_2000;
        read_en = 1'b1;
        #3;
        check_eq("fr_first_hit", 32'(hit), 32'h0);
        @(negedge clk);
        flush = 1'b1;
        #3;
        check_eq("fr_mem_req", 32'(mem_req), 32'h1);
        @(negedge clk);
        flush       = 1'b0;
        mem_ready   = 1'b1;
        mem_data_in = gen_line(32'h2000);
        #3;
        check_eq("fr_ready_hit", 32'(hit), 32'h0);
        @(negedge clk);
        mem_ready = 1'b0;
        read_en   = 1'b0;
        model_clear();
        fetch(32'h0000_2000, 0, 1'b0, '0);

        repeat (2) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 SHALL have parameter NUM_SETS, default 64: sets; power of two, >= 2.
REQ-002 SHALL have parameter NUM_WAYS, default 2: associativity; only 1 or 2 legal.
REQ-003 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line; power of two, >= 1.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port addr, input, 32: processor byte address.
REQ-007 SHALL have port read_en, input, 1: fetch request, held until hit.
REQ-008 SHALL have port flush, input, 1: invalidate all lines.
REQ-009 SHALL have port data_out, output, 32: fetched word, valid when hit=1.
REQ-010 SHALL have port hit, output, 1: data_out valid this cycle.
REQ-011 SHALL have port mem_addr, output, 32: line-aligned refill address.
REQ-012 SHALL have port mem_req, output, 1: refill request, held until mem_ready.
REQ-013 SHALL have port mem_data_in, input, 32*LINE_WORDS: refill line; word k at bits [32k+31:32k].
REQ-014 SHALL have port mem_ready, input, 1: mem_data_in valid; completes refill.

Function
REQ-015 SHALL split addr: [1:0] ignored; offset OB=log2(LINE_WORDS)+2 bits; index log2(NUM_SETS) bits above; tag = remaining upper bits.
REQ-016 SHALL use FSM states IDLE and REFILL only.
REQ-017 In IDLE, hit SHALL be combinational = read_en and (valid and tag match in any way of indexed set); data_out = word addr[OB-1:2] of matching line (0-cycle hit latency).
REQ-018 When hit=0, data_out SHALL be 0.
REQ-019 IDLE with read_en and no match SHALL latch addr and enter REFILL next cycle; mem_req=1, mem_addr = latched addr with low OB bits zero.
REQ-020 In REFILL, hit SHALL be 0; addr/read_en changes SHALL NOT affect the refill in progress.
REQ-021 On mem_ready in REFILL, SHALL write line, tag, valid=1 into victim way, clear mem_req, return IDLE; a held read_en hits the following cycle.
REQ-022 Victim SHALL be lowest-index invalid way; if all valid, the LRU way (NUM_WAYS=2) or way 0 (NUM_WAYS=1).
REQ-023 Per set, LRU bit SHALL point to the other way after every hit or refill install into a way.
REQ-024 mem_ready outside REFILL SHALL be ignored.
REQ-025 flush in IDLE SHALL clear all valid and LRU bits next edge; hit SHALL be 0 during a flush cycle.
REQ-026 flush in REFILL SHALL set flush_pending; on mem_ready the line SHALL be discarded (not installed), all valid and LRU bits cleared, flush_pending cleared, return IDLE.
REQ-027 Read_en dropped mid-refill SHALL NOT abort; line is still installed.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, all valid/LRU bits 0, flush_pending 0, mem_req 0, mem_addr 0, hit 0, data_out 0, including mid-refill.
REQ-029 Data and tag arrays SHALL NOT require reset.

Structure
REQ-030 Package icache_pkg SHALL hold the FSM state enum and word-width/address-width constants.
REQ-031 Per-way tag/valid/data storage and match logic SHALL be sub-module icache_way, instantiated NUM_WAYS times; FSM and LRU reside in icache_sa.

Verification
REQ-032 Cold miss: read_en, addr=0x0000_1004 -> next cycle mem_req=1, mem_addr=0x0000_1000; mem_ready with word1=0xDEADBEEF -> next cycle hit=1, data_out=0xDEADBEEF.
REQ-033 2-way conflict (defaults): fill 0x1000, fill 0x1400, re-read 0x1000 (hit), read 0x1800 -> refill evicts 0x1400; subsequent 0x1000 hits, 0x1400 misses.
REQ-034 Flush mid-refill: miss on 0x2000, assert flush one cycle, then mem_ready -> read 0x2000 misses again, mem_addr=0x0000_2000.
REQ-035 Reset mid-refill: rst=0 while mem_req=1 -> mem_req=0 immediately; after release, read of any previously filled address misses.
REQ-036 NUM_WAYS=1, NUM_SETS=16: fill 0x0100 then 0x0200 (same index) -> 0x0100 misses afterward.
REQ-037 Held hit: read_en held on 0x1008 after fill, mem_ready pulsed spuriously -> hit stays 1, mem_req stays 0.
